// File: rtl/ps2_scancode_sequencer.sv
// PS/2 Set-2 scancode sequencer: turns the receiver's byte strobes into
// decoded key events (code, extended, break). Prefix sequences are parsed by
// a small FSM, and each finished sequence is queued in an event FIFO that
// the consumer reads through a valid/ready handshake.
module ps2_scancode_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_data,
    input  logic                     byte_valid,
    output logic [7:0]               ev_code,
    output logic                     ev_ext,
    output logic                     ev_break,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               status_code,
    output logic                     status_pulse,
    output logic                     sync_err,
    output logic                     overflow,
    input  logic                     overflow_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      pcnt_q, pcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            push, abort, status_upd;
    logic [7:0]      push_code;
    logic            push_ext, push_brk;

    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push, do_pop, full, drop;
    logic            status_pulse_q, sync_err_q, overflow_q;
    logic [7:0]      status_code_q;
    logic [9:0]      head;

    // Keyboard status/response bytes are never part of a key sequence.
    function automatic logic is_status(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    // Next-state logic: prefix parsing, pause byte counting and the inter-byte timeout.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        tcnt_d     = tcnt_q;
        push       = 1'b0;
        push_code  = byte_data;
        push_ext   = 1'b0;
        push_brk   = 1'b0;
        abort      = 1'b0;
        status_upd = 1'b0;
        if (byte_valid) begin
            // A byte always beats the timeout in the same cycle.
            tcnt_d = '0;
            if (is_status(byte_data)) begin
                status_upd = 1'b1;
                if (state_q != S_IDLE) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (byte_data == 8'hE0) state_d = S_E0;
                        else if (byte_data == 8'hF0) state_d = S_F0;
                        else if (byte_data == 8'hE1) begin
                            state_d = S_PAUSE;
                            pcnt_d  = 3'd1;
                        end else push = 1'b1;
                    end
                    S_E0: begin
                        if (byte_data == 8'hF0) state_d = S_E0F0;
                        else if (byte_data == 8'hE0) state_d = S_E0;
                        else if (byte_data == 8'hE1) begin
                            abort   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            push     = 1'b1;
                            push_ext = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                    S_F0, S_E0F0: begin
                        state_d = S_IDLE;
                        if (byte_data inside {8'hE0, 8'hF0, 8'hE1}) abort = 1'b1;
                        else begin
                            push     = 1'b1;
                            push_ext = (state_q == S_E0F0);
                            push_brk = 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        // Pause is a fixed 8-byte sequence; only the count matters.
                        if (pcnt_q == 3'd7) begin
                            push      = 1'b1;
                            push_code = 8'hE1;
                            push_ext  = 1'b1;
                            state_d   = S_IDLE;
                        end else pcnt_d = pcnt_q + 3'd1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (state_q == S_IDLE) begin
            tcnt_d = '0;
        end else if (tcnt_q == TO_LAST) begin
            abort   = 1'b1;
            state_d = S_IDLE;
            tcnt_d  = '0;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // FIFO control: a pop frees the slot first, so push+pop on a full FIFO both happen.
    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        do_pop  = ev_ready && (count_q != '0);
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
    end

    // Parser state, FIFO pointers and registered status/error strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pcnt_q         <= '0;
            tcnt_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            status_code_q  <= '0;
            status_pulse_q <= 1'b0;
            sync_err_q     <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pcnt_q         <= pcnt_d;
            tcnt_q         <= tcnt_d;
            status_pulse_q <= status_upd;
            sync_err_q     <= abort;
            if (status_upd) status_code_q <= byte_data;
            if (drop) overflow_q <= 1'b1;
            else if (overflow_clr) overflow_q <= 1'b0;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Event storage; contents are don't-care until the level says otherwise.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= {push_code, push_ext, push_brk};
    end

    // Head outputs are forced to zero while empty so reset/empty look clean.
    always_comb begin
        head         = mem[rd_ptr_q];
        ev_valid     = (count_q != '0);
        ev_code      = ev_valid ? head[9:2] : 8'h00;
        ev_ext       = ev_valid & head[1];
        ev_break     = ev_valid & head[0];
        fifo_level   = count_q;
        status_code  = status_code_q;
        status_pulse = status_pulse_q;
        sync_err     = sync_err_q;
        overflow     = overflow_q;
    end
endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Directed bench for ps2_scancode_sequencer: make/break decoding, overflow,
// timeout, pause/status handling and asynchronous reset.
module tb_ps2_scancode_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [7:0] ev_code;
    logic       ev_ext, ev_break, ev_valid, ev_ready;
    logic [2:0] fifo_level;
    logic [7:0] status_code;
    logic       status_pulse, sync_err, overflow, overflow_clr;

    int errors = 0;
    int checks = 0;

    ps2_scancode_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .fifo_level(fifo_level), .status_code(status_code),
        .status_pulse(status_pulse), .sync_err(sync_err), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    // One-cycle byte strobe; returns on the negedge after the sampling posedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        $display("tx byte %h -> valid=%b code=%h ext=%b brk=%b lvl=%0d stat=%h sp=%b se=%b ovf=%b",
                 b, ev_valid, ev_code, ev_ext, ev_break, fifo_level, status_code,
                 status_pulse, sync_err, overflow);
    endtask

    task automatic pop_one();
        @(negedge clk);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; byte_data = 8'h00; byte_valid = 1'b0;
        ev_ready = 1'b0; overflow_clr = 1'b0;
        #12;
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_break, fifo_level, status_code, status_pulse, sync_err, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b code=%h lvl=%0d stat=%h ovf=%b want all zero",
                     ev_valid, ev_code, fifo_level, status_code, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_make();
        ev_ready = 1'b1;
        @(negedge clk);
        byte_data = 8'h1C; byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL make_event: got v=%b code=%h ext=%b brk=%b want v=1 code=1c ext=0 brk=0",
                     ev_valid, ev_code, ev_ext, ev_break);
        end
        @(negedge clk);
        ev_ready = 1'b0;
        checks++;
        if ({ev_valid, fifo_level} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL make_popped: got v=%b lvl=%0d want v=0 lvl=0", ev_valid, fifo_level);
        end
    endtask

    task automatic test_ext_break();
        send_byte(8'hE0);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL extbrk_after_e0: got valid=%b want 0", ev_valid);
        end
        send_byte(8'hF0);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL extbrk_after_f0: got valid=%b want 0", ev_valid);
        end
        send_byte(8'h75);
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_break, fifo_level} !== {1'b1, 8'h75, 1'b1, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL extbrk_event: got v=%b code=%h ext=%b brk=%b lvl=%0d want 1 75 1 1 1",
                     ev_valid, ev_code, ev_ext, ev_break, fifo_level);
        end
        pop_one();
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++; $display("FAIL extbrk_drain: got lvl=%0d want 0", fifo_level);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] mk [5];
        logic [7:0] exp2 [4];
        mk = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
        exp2 = '{8'h16, 8'h1E, 8'h26, 8'h25};
        for (int i = 0; i < 5; i++) send_byte(mk[i]);
        checks++;
        if ({fifo_level, overflow} !== {3'd4, 1'b1}) begin
            errors++; $display("FAIL ovf_full: got lvl=%0d ovf=%b want lvl=4 ovf=1", fifo_level, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_code !== mk[i]) begin
                errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, ev_code, mk[i]);
            end
            pop_one();
        end
        checks++;
        if ({ev_valid, fifo_level} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL ovf_empty: got v=%b lvl=%0d want 0 0", ev_valid, fifo_level);
        end
        @(negedge clk); overflow_clr = 1'b1;
        @(negedge clk); overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got ovf=%b want 0", overflow);
        end
        for (int i = 0; i < 4; i++) send_byte(mk[i]);
        // push 25 and pop 15 in the same cycle while full
        @(negedge clk);
        byte_data = 8'h25; byte_valid = 1'b1; ev_ready = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; ev_ready = 1'b0;
        checks++;
        if ({fifo_level, overflow, ev_code} !== {3'd4, 1'b0, 8'h16}) begin
            errors++;
            $display("FAIL ovf_pushpop_full: got lvl=%0d ovf=%b head=%h want lvl=4 ovf=0 head=16",
                     fifo_level, overflow, ev_code);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_code !== exp2[i]) begin
                errors++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, ev_code, exp2[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_timeout();
        int early = 0;
        send_byte(8'hE0);
        // the strobe edge has passed; the abort registers 50 edges later
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            if (sync_err !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL timeout_early: got %0d early sync_err cycles want 0", early);
        end
        @(negedge clk);
        checks++;
        if (sync_err !== 1'b1) begin
            errors++; $display("FAIL timeout_pulse: got sync_err=%b want 1", sync_err);
        end
        @(negedge clk);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse_width: got sync_err=%b want 0", sync_err);
        end
        send_byte(8'h1C);
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_recover: got v=%b code=%h ext=%b brk=%b want 1 1c 0 0",
                     ev_valid, ev_code, ev_ext, ev_break);
        end
        pop_one();
    endtask

    task automatic test_pause_status();
        logic [7:0] seq [8];
        int early = 0;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 7; i++) begin
            send_byte(seq[i]);
            if (ev_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL pause_early: got %0d early events want 0", early);
        end
        send_byte(seq[7]);
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_break, fifo_level} !== {1'b1, 8'hE1, 1'b1, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL pause_event: got v=%b code=%h ext=%b brk=%b lvl=%0d want 1 e1 1 0 1",
                     ev_valid, ev_code, ev_ext, ev_break, fifo_level);
        end
        pop_one();
        send_byte(8'hFA);
        checks++;
        if ({status_pulse, status_code, ev_valid, sync_err} !== {1'b1, 8'hFA, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL status_idle: got sp=%b stat=%h v=%b se=%b want 1 fa 0 0",
                     status_pulse, status_code, ev_valid, sync_err);
        end
        @(negedge clk);
        checks++;
        if (status_pulse !== 1'b0) begin
            errors++; $display("FAIL status_pulse_width: got %b want 0", status_pulse);
        end
        send_byte(8'hF0);
        send_byte(8'hAA);
        checks++;
        if ({sync_err, status_pulse, status_code, ev_valid} !== {1'b1, 1'b1, 8'hAA, 1'b0}) begin
            errors++;
            $display("FAIL status_abort: got se=%b sp=%b stat=%h v=%b want 1 1 aa 0",
                     sync_err, status_pulse, status_code, ev_valid);
        end
        send_byte(8'h1C);
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL status_recover: got v=%b code=%h ext=%b brk=%b want 1 1c 0 0",
                     ev_valid, ev_code, ev_ext, ev_break);
        end
        pop_one();
    endtask

    task automatic test_async_reset();
        send_byte(8'h15);
        send_byte(8'h16);
        send_byte(8'hF0);
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++; $display("FAIL rst_prefill: got lvl=%0d want 2", fifo_level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_break, fifo_level, status_code, status_pulse, sync_err, overflow} !== '0) begin
            errors++;
            $display("FAIL rst_async: got v=%b code=%h lvl=%0d stat=%h want all zero",
                     ev_valid, ev_code, fifo_level, status_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h1C);
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_break, fifo_level} !== {1'b1, 8'h1C, 1'b0, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL rst_recover: got v=%b code=%h ext=%b brk=%b lvl=%0d want 1 1c 0 0 1",
                     ev_valid, ev_code, ev_ext, ev_break, fifo_level);
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_overflow();
        test_timeout();
        test_pause_status();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
